// File: rtl/data_mem_responder.sv
// Word-organised data RAM responder for the LSU memory port, with byte-lane writes and a wait-state FSM.
// Optional out-of-range fault reporting is enabled by defining DMEM_FAULT_EN.
module data_mem_responder #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipSelect,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [3:0]  mask,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        ready
`ifdef DMEM_FAULT_EN
    ,
    output logic        fault
`endif
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [3:0]            mask_q, mask_d;
    logic [31:0]           data_q, data_d;
    logic                  wr_q, wr_d;
    logic                  both_q, both_d;
    logic                  oor_q, oor_d;
    logic                  ready_q, ready_d;
    logic [31:0]           dout_q, dout_d;

    logic [31:0]           mem_q [DEPTH];

    logic                  req;
    logic [DEPTH_LOG2-1:0] in_idx;
    logic                  in_oor;
    logic                  unused_addr;

    logic                  commit;
    logic [DEPTH_LOG2-1:0] c_idx;
    logic [3:0]            c_mask;
    logic [31:0]           c_data;
    logic                  c_wr;
    logic                  c_both;
    logic                  c_oor;
    logic                  mem_wr;

    assign req         = chipSelect & (rd_en | wr_en);
    assign in_idx      = addr[DEPTH_LOG2+1:2];
    assign unused_addr = ^{addr[1:0], addr[31:DEPTH_LOG2+2]};

`ifdef DMEM_FAULT_EN
    assign in_oor = |addr[31:DEPTH_LOG2+2];
`else
    assign in_oor = 1'b0;
`endif

    // With zero wait states the access commits on the accept edge straight from the bus inputs;
    // otherwise it commits later from the latched copy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        data_d  = data_q;
        wr_d    = wr_q;
        both_d  = both_q;
        oor_d   = oor_q;
        commit  = 1'b0;
        c_idx   = idx_q;
        c_mask  = mask_q;
        c_data  = data_q;
        c_wr    = wr_q;
        c_both  = both_q;
        c_oor   = oor_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d  = in_idx;
                    mask_d = mask;
                    data_d = dataIn;
                    wr_d   = wr_en;
                    both_d = wr_en & rd_en;
                    oor_d  = in_oor;
                    cnt_d  = CNT_INIT;
                    if (WAIT_STATES == 0) begin
                        commit  = 1'b1;
                        c_idx   = in_idx;
                        c_mask  = mask;
                        c_data  = dataIn;
                        c_wr    = wr_en;
                        c_both  = wr_en & rd_en;
                        c_oor   = in_oor;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_wr  = commit & c_wr & ~c_oor;
    assign ready_d = commit;

    always_comb begin
        dout_d = dout_q;
        if (commit) begin
            if (c_oor || c_both) begin
                dout_d = '0;
            end else if (!c_wr) begin
                dout_d = mem_q[c_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            both_q  <= 1'b0;
            oor_q   <= 1'b0;
            ready_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            both_q  <= both_d;
            oor_q   <= oor_d;
            ready_q <= ready_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (c_mask[b]) begin
                    mem_q[c_idx][8*b +: 8] <= c_data[8*b +: 8];
                end
            end
        end
    end

`ifdef DMEM_FAULT_EN
    logic fault_q, fault_d;

    // Set only on the commit edge, so it is high exactly when ready is.
    assign fault_d = commit & c_oor;

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`endif

    assign dataOut = dout_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder: one instance with one wait state, one with none.
// Fault expectations apply when DMEM_FAULT_EN is defined.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        sel = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  mask = '0;
    logic [31:0] din = '0;

    logic        cs1, cs0;
    logic [31:0] dout1, dout0;
    logic        ready1, ready0;
    logic        fault1, fault0;

    int checks = 0;
    int errors = 0;

`ifdef DMEM_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
    assign fault1 = 1'b0;
    assign fault0 = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        chk;
        logic        flt;
    } exp_t;

    exp_t sb[$];

    assign cs1 = cs & ~sel;
    assign cs0 = cs & sel;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(1)) dut_ws1 (
        .clk(clk), .reset(reset), .chipSelect(cs1), .rd_en(rd), .wr_en(wr),
        .addr(addr), .mask(mask), .dataIn(din), .dataOut(dout1), .ready(ready1)
`ifdef DMEM_FAULT_EN
        , .fault(fault1)
`endif
    );

    data_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .reset(reset), .chipSelect(cs0), .rd_en(rd), .wr_en(wr),
        .addr(addr), .mask(mask), .dataIn(din), .dataOut(dout0), .ready(ready0)
`ifdef DMEM_FAULT_EN
        , .fault(fault0)
`endif
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request to the selected instance; lat counts posedges from driving until ready is seen.
    task automatic access(input string tag, input logic s, input logic r, input logic w,
                          input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                          input logic chk, input logic [31:0] exp_data, input logic exp_flt,
                          input int lat, input logic hold, input logic toggle);
        int   n;
        logic got;
        exp_t e;
        sel  = s;
        rd   = r;
        wr   = w;
        addr = a;
        mask = m;
        din  = d;
        cs   = 1'b1;
        sb.push_back('{data: exp_data, chk: chk, flt: exp_flt});
        n   = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1 && toggle) begin
                addr = a ^ 32'h4;
                rd   = ~r;
                wr   = ~w;
            end
            got = s ? ready0 : ready1;
        end
        if (!hold) begin
            cs = 1'b0;
            rd = 1'b0;
            wr = 1'b0;
        end
        check32({tag, "_latency"}, 32'(n), 32'(lat));
        e = sb.pop_front();
        if (e.chk) check32({tag, "_data"}, s ? dout0 : dout1, e.data);
`ifdef DMEM_FAULT_EN
        check32({tag, "_fault"}, {31'd0, s ? fault0 : fault1}, {31'd0, e.flt});
`endif
        @(posedge clk);
        #1;
        check32({tag, "_ready_drop"}, {31'd0, s ? ready0 : ready1}, 32'd0);
`ifdef DMEM_FAULT_EN
        check32({tag, "_fault_drop"}, {31'd0, s ? fault0 : fault1}, 32'd0);
`endif
        if (e.chk) check32({tag, "_data_hold"}, s ? dout0 : dout1, e.data);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check32("rst_ready1", {31'd0, ready1}, 32'd0);
        check32("rst_ready0", {31'd0, ready0}, 32'd0);
        check32("rst_dout1", dout1, 32'd0);
        check32("rst_dout0", dout0, 32'd0);
`ifdef DMEM_FAULT_EN
        check32("rst_fault1", {31'd0, fault1}, 32'd0);
        check32("rst_fault0", {31'd0, fault0}, 32'd0);
`endif

        // Basic read and byte-lane merge on the one-wait-state instance
        access("t1_rd10", 1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 32'h0, 1'b0, 2, 1'b0, 1'b0);
        access("t2_wr_full", 1'b0, 1'b0, 1'b1, 32'h20, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 2, 1'b0, 1'b0);
        access("t2_wr_lane1", 1'b0, 1'b0, 1'b1, 32'h20, 4'b0010, 32'h0000AA00, 1'b0, 32'h0, 1'b0, 2, 1'b0, 1'b0);
        access("t2_rd20", 1'b0, 1'b1, 1'b0, 32'h23, 4'h0, 32'h0, 1'b1, 32'hDEADAAEF, 1'b0, 2, 1'b0, 1'b0);

        // Read+write together acts as a write with zero read data; empty mask leaves RAM alone
        access("dual_rw", 1'b0, 1'b1, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, 2, 1'b0, 1'b0);
        access("dual_rd20", 1'b0, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b1, 32'hDEADAAEF, 1'b0, 2, 1'b0, 1'b0);

        // Inputs changed during WAIT must not affect the latched write
        access("t4_toggle", 1'b0, 1'b0, 1'b1, 32'h40, 4'hF, 32'h11223344, 1'b0, 32'h0, 1'b0, 2, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check32("t4_no_extra_ready", {31'd0, ready1}, 32'd0);
        end
        access("t4_rd40", 1'b0, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1, 32'h11223344, 1'b0, 2, 1'b0, 1'b0);
        access("t4_rd44", 1'b0, 1'b1, 1'b0, 32'h44, 4'hF, 32'h0, 1'b1, 32'h0, 1'b0, 2, 1'b0, 1'b0);

        // Out-of-range address: fault or wrap to word 0
        access("t6_wr0", 1'b0, 1'b0, 1'b1, 32'h0, 4'hF, 32'hA1B2C3D4, 1'b0, 32'h0, 1'b0, 2, 1'b0, 1'b0);
        access("t6_wr_oor", 1'b0, 1'b0, 1'b1, 32'h1000, 4'b0001, 32'h00000055, FAULT_EN, 32'h0, FAULT_EN,
               2, 1'b0, 1'b0);
        access("t6_rd0", 1'b0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1,
               FAULT_EN ? 32'hA1B2C3D4 : 32'hA1B2C355, 1'b0, 2, 1'b0, 1'b0);
        access("t6_rd_oor", 1'b0, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0, 1'b1,
               FAULT_EN ? 32'h0 : 32'hA1B2C355, FAULT_EN, 2, 1'b0, 1'b0);

        // Zero wait states, request held across the response and retargeted to a read
        access("t3_wr4", 1'b1, 1'b0, 1'b1, 32'h4, 4'hF, 32'h12345678, 1'b0, 32'h0, 1'b0, 1, 1'b1, 1'b0);
        access("t3_rd4", 1'b1, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0, 1'b1, 32'h12345678, 1'b0, 1, 1'b0, 1'b0);

        // Reset during WAIT of a write: no response, write discarded
        sel  = 1'b0;
        rd   = 1'b0;
        wr   = 1'b1;
        addr = 32'h8;
        mask = 4'hF;
        din  = 32'hCAFEF00D;
        cs   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cs    = 1'b0;
        wr    = 1'b0;
        @(posedge clk);
        #1;
        check32("t5_ready_in_reset", {31'd0, ready1}, 32'd0);
        check32("t5_dout_in_reset", dout1, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check32("t5_no_ready", {31'd0, ready1}, 32'd0);
        end
        access("t5_rd8", 1'b0, 1'b1, 1'b0, 32'h8, 4'hF, 32'h0, 1'b1, 32'h0, 1'b0, 2, 1'b0, 1'b0);
        access("t5_rd4_ws0", 1'b1, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0, 1'b1, 32'h0, 1'b0, 1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
